// File: rtl/bidarb_pkg.sv
// bidarb_pkg: shared state encoding, master count and bid/balance types for the bid auction arbiter
package bidarb_pkg;
   localparam int NUM_M = 4;
   localparam int IDX_W = 2;
   localparam int BID_W = 4;
   localparam int DEF_BAL_W = 10;
   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
   typedef logic [BID_W-1:0] bid_t;
   typedef logic [DEF_BAL_W-1:0] bal_t;
   typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/bidarb_replenish.sv
// bidarb_replenish: free-running 0..MAX_CLK-1 counter, tick is high for the single cycle before wrap
module bidarb_replenish #(
   parameter int MAX_CLK = 64
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = $clog2(MAX_CLK);
   logic [CW-1:0] cnt;
   assign tick = cnt == CW'(MAX_CLK - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bid_auction_arb.sv
// bid_auction_arb: credit-based bid auction for 4 masters with round-robin tie break and periodic replenish.
// Optional grant timeout with refund when BIDARB_TIMEOUT_EN is defined.
module bid_auction_arb #(
   parameter int NUM_M   = bidarb_pkg::NUM_M,
   parameter int BAL_W   = 10,
   parameter int AMT     = 8,
   parameter int MAX_CLK = 64,
   parameter int MAX_AMT = 512,
   parameter int TMO     = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  bidarb_pkg::bid_t [NUM_M-1:0]     bid,
   input  logic [NUM_M-1:0]                 xfr,
   output logic [NUM_M-1:0]                 grant,
   output logic [NUM_M-1:0][BAL_W-1:0]      balance,
   output logic                             busy
);
   import bidarb_pkg::*;
   localparam int CW = BAL_W + 2;
   state_t state;
   idx_t last, owner, win;
   bid_t owner_bid;
   logic seen, any_elig, tick, fall, tmo;
   logic [NUM_M-1:0] debit, refund;
   logic [NUM_M-1:0][BAL_W-1:0] nxt_bal;
   bidarb_replenish #(.MAX_CLK(MAX_CLK)) u_rep (.clk(clk), .rst(rst), .tick(tick));
   // scan in round-robin order from last+1; strict > keeps the earliest of equal bids
   always_comb begin
      idx_t idx;
      bid_t best;
      idx = '0;
      best = '0;
      win = '0;
      any_elig = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         idx = last + idx_t'(i + 1);
         if (balance[idx] >= BAL_W'(bid[idx]) && bid[idx] > best) begin
            win = idx;
            best = bid[idx];
            any_elig = 1'b1;
         end
      end
   end
   assign fall = state == OWN && seen && !xfr[owner];
`ifdef BIDARB_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   assign tmo = state == OWN && !seen && !xfr[owner] && tmo_cnt == TW'(TMO - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) tmo_cnt <= '0;
      else if (state != OWN) tmo_cnt <= '0;
      else if (!seen && !xfr[owner]) tmo_cnt <= tmo_cnt + 1'b1;
`else
   logic unused_tmo;
   assign unused_tmo = TMO != 0;
   assign tmo = 1'b0;
`endif
   for (genvar m = 0; m < NUM_M; m++) begin : g_bal
      logic [CW-1:0] nb;
      assign debit[m] = state == IDLE && any_elig && win == idx_t'(m);
      assign refund[m] = tmo && owner == idx_t'(m);
      assign nb = CW'(balance[m]) - (debit[m] ? CW'(bid[m]) : '0)
                + (refund[m] ? CW'(owner_bid) : '0) + (tick ? CW'(AMT) : '0);
      assign nxt_bal[m] = nb > CW'(MAX_AMT) ? BAL_W'(MAX_AMT) : nb[BAL_W-1:0];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         busy <= 1'b0;
         last <= idx_t'(NUM_M - 1);
         owner <= '0;
         owner_bid <= '0;
         seen <= 1'b0;
         balance <= {NUM_M{BAL_W'(MAX_AMT)}};
      end else begin
         balance <= nxt_bal;
         case (state)
            IDLE: if (any_elig) begin
               state <= OWN;
               grant <= NUM_M'(1) << win;
               busy <= 1'b1;
               owner <= win;
               owner_bid <= bid[win];
               last <= win;
               seen <= 1'b0;
            end
            OWN: begin
               seen <= seen | xfr[owner];
               if (fall || tmo) begin
                  state <= GAP;
                  grant <= '0;
               end
            end
            GAP: begin
               state <= IDLE;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_bid_auction_arb.sv
// tb_bid_auction_arb: directed checks of auction, tie break, replenish, saturation, hold/timeout and async reset
module tb_bid_auction_arb;
   logic clk = 1'b0;
   logic rst;
   logic [3:0][3:0] bid;
   logic [3:0] xfr, grant;
   logic [3:0][9:0] balance;
   logic busy;
   int n_chk = 0, n_err = 0, cyc = 0;
   bid_auction_arb dut (.clk(clk), .rst(rst), .bid(bid), .xfr(xfr), .grant(grant), .balance(balance), .busy(busy));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bid = '0;
      xfr = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask
   initial begin
      do_reset();
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_bal3", 32'(balance[3]), 512);
      bid[0] = 4'd5;
      step();
      check("a_grant", 32'(grant), 1);
      check("a_bal0", 32'(balance[0]), 507);
      check("a_busy", 32'(busy), 1);
      bid = '0;
      xfr[0] = 1'b1;
      step(); step(); step();
      check("a_hold", 32'(grant), 1);
      check("a_bal0_hold", 32'(balance[0]), 507);
      xfr[0] = 1'b0;
      step();
      check("a_gap_grant", 32'(grant), 0);
      check("a_gap_busy", 32'(busy), 1);
      step();
      check("a_idle_busy", 32'(busy), 0);
      check("a_idle_grant", 32'(grant), 0);
      // tie at 9 between m2/m3 from reset, then a second tie after m2 won
      do_reset();
      bid[1] = 4'd4; bid[2] = 4'd9; bid[3] = 4'd9;
      step();
      check("b_grant", 32'(grant), 4);
      check("b_bal2", 32'(balance[2]), 503);
      check("b_bal3", 32'(balance[3]), 512);
      bid = '0;
      xfr[1] = 1'b1;
      step();
      xfr[1] = 1'b0;
      step();
      check("b_nonowner", 32'(grant), 4);
      xfr[2] = 1'b1;
      step();
      xfr[2] = 1'b0;
      step(); step();
      bid[0] = 4'd3; bid[3] = 4'd3;
      step();
      check("b_rr_grant", 32'(grant), 8);
      check("b_rr_bal3", 32'(balance[3]), 509);
      check("b_rr_bal0", 32'(balance[0]), 512);
      // 35 grants of 15 to m1 with ticks at edges 64 and 128 leave it at 3
      do_reset();
      for (int n = 0; n < 35; n++) begin
         bid[1] = 4'd15;
         step();
         bid[1] = 4'd0;
         xfr[1] = 1'b1;
         step();
         xfr[1] = 1'b0;
         step(); step();
      end
      check("c_bal1_low", 32'(balance[1]), 3);
      bid[1] = 4'd4;
      while (cyc < 191) step();
      check("c_wait_grant", 32'(grant), 0);
      check("c_wait_bal1", 32'(balance[1]), 3);
      step();
      check("c_tick_grant", 32'(grant), 0);
      check("c_tick_bal1", 32'(balance[1]), 11);
      check("c_tick_bal0", 32'(balance[0]), 512);
      step();
      check("c_late_grant", 32'(grant), 2);
      check("c_late_bal1", 32'(balance[1]), 7);
      // debit of 2 from 510 on the replenish edge saturates to 512
      do_reset();
      bid[0] = 4'd2;
      step();
      check("d_bal0", 32'(balance[0]), 510);
      bid = '0;
      xfr[0] = 1'b1;
      step();
      xfr[0] = 1'b0;
      step(); step();
      while (cyc < 63) step();
      check("d_pre_bal0", 32'(balance[0]), 510);
      bid[0] = 4'd2;
      step();
      check("d_grant", 32'(grant), 1);
      check("d_sat_bal0", 32'(balance[0]), 512);
      // owner never raises xfr
      do_reset();
      bid[0] = 4'd6;
      step();
      check("e_bal0", 32'(balance[0]), 506);
      bid = '0;
`ifdef BIDARB_TIMEOUT_EN
      repeat (7) step();
      check("e_tmo_pre", 32'(grant), 1);
      step();
      check("e_tmo_grant", 32'(grant), 0);
      check("e_tmo_bal0", 32'(balance[0]), 512);
`else
      repeat (30) step();
      check("e_hold_grant", 32'(grant), 1);
      check("e_hold_busy", 32'(busy), 1);
      check("e_hold_bal0", 32'(balance[0]), 506);
`endif
      // asynchronous reset in the middle of ownership
      do_reset();
      bid[2] = 4'd7;
      step();
      check("f_grant", 32'(grant), 4);
      check("f_bal2", 32'(balance[2]), 505);
      #3 rst = 1'b1;
      #1;
      check("f_async_grant", 32'(grant), 0);
      check("f_async_busy", 32'(busy), 0);
      check("f_async_bal2", 32'(balance[2]), 512);
      bid = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("f_rel_grant", 32'(grant), 0);
      check("f_rel_bal2", 32'(balance[2]), 512);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bid_auction_arb.md
BID_AUCTION_ARB -- requirements
Module: bid_auction_arb

Interface
REQ-001 SHALL have parameter NUM_M, default 4, number of masters (fixed 4 in this release).
REQ-002 SHALL have parameter BAL_W, default 10, balance width in bits.
REQ-003 SHALL have parameter AMT, default 8, credit added per replenish tick.
REQ-004 SHALL have parameter MAX_CLK, default 64, cycles between replenish ticks (>=2).
REQ-005 SHALL have parameter MAX_AMT, default 512, balance ceiling (< 2**BAL_W).
REQ-006 SHALL have parameter TMO, default 8, cycles allowed from grant to first xfr.
REQ-007 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port bid  input  4x4  per-master bid value; 0 = no request.
REQ-010 SHALL have port xfr  input  4  per-master transfer-in-progress.
REQ-011 SHALL have port grant  output  4  one-hot registered grant, at most one bit set.
REQ-012 SHALL have port balance  output  4xBAL_W  current credit per master.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, OWN, GAP.
REQ-015 IDLE: a master is eligible iff bid!=0 and balance>=bid; if any eligible, next cycle go OWN with grant set to winner (latency 1 cycle from bid sample).
REQ-016 Winner = highest eligible bid; ties resolved round-robin starting at index (last_winner+1) mod 4; last_winner resets to 3 so master 0 wins the first tie.
REQ-017 On the grant edge, winner balance SHALL be debited by its sampled bid; bid changes while in OWN are ignored.
REQ-018 OWN: grant held while owner xfr=1; first falling edge of owner xfr after it was seen high moves to GAP.
REQ-019 GAP: all grant bits 0 for exactly one cycle, then IDLE.
REQ-020 xfr from non-owners SHALL be ignored.
REQ-021 Replenish counter counts 0..MAX_CLK-1 and wraps; on wrap every balance += AMT, saturating at MAX_AMT.
REQ-022 Debit and replenish in same cycle on same master: balance = min(balance - bid + AMT, MAX_AMT).
REQ-023 No eligible master in IDLE: remain IDLE, grant=0, balances change only by replenish.
REQ-024 Balance SHALL never underflow (eligibility guarantees balance>=bid).

Reset
REQ-025 rst asserted SHALL immediately force grant=0, busy=0, state=IDLE, independent of clk.
REQ-026 Reset values: every balance=MAX_AMT, replenish counter=0, last_winner=3, timeout counter=0.
REQ-027 Reset mid-OWN SHALL abandon the transfer without refunding the debit (balance reinitialised anyway).

Configuration
REQ-028 Macro BIDARB_TIMEOUT_EN defined: in OWN, if owner xfr has not been seen high within TMO cycles after grant, go GAP and refund the debited bid (saturating at MAX_AMT).
REQ-029 Macro BIDARB_TIMEOUT_EN undefined: no timeout counter; grant held until owner xfr rises then falls.

Structure
REQ-030 Package bidarb_pkg SHALL hold the state enum, NUM_M, and bid/balance typedefs.
REQ-031 Sub-module bidarb_replenish SHALL contain the MAX_CLK tick counter and output a one-cycle tick.

Verification
REQ-032 Reset release, bid={0,0,0,5} (m0=5), xfr0 high 3 cycles -> grant=0001 one cycle after bid, balance0=507, grant drops, one GAP cycle.
REQ-033 bids m1=4, m2=9, m3=9, last_winner=3 -> m2 granted (tie at 9 resolved rr from 0), balance2=503.
REQ-034 balance1 forced to 3 via grants, m1 bid 4 alone -> no grant until replenish tick lifts balance1 to 11, then granted next IDLE cycle.
REQ-035 balance=510, replenish tick on same cycle as debit of 2 -> balance = min(510-2+8,512)=512.
REQ-036 With BIDARB_TIMEOUT_EN: m0 bid 6, xfr0 never asserted -> grant revoked after 8 cycles, balance0 restored to 512; without macro grant held indefinitely.
REQ-037 rst pulsed mid-OWN -> grant=0 asynchronously, all balances=512 after release.
